// File: rtl/aes_sbox_sched.sv
// aes_sbox_sched: time-shares LANES S-boxes between a 128-bit state SubBytes
// requester and a 32-bit key-word SubWord requester. Round-robin arbitration,
// in-place chunked substitution and a valid/ready result handshake.

// Single AES forward S-box, purely combinational table lookup.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] bit_lo;

  // Entry 0 sits in the top byte, so the low bit of entry x is 8*(255-x).
  always_comb begin
    bit_lo   = {~in_byte, 3'b000};
    out_byte = SBOX_TABLE[bit_lo +: 8];
  end

endmodule

module aes_sbox_sched #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_req_valid,
  output logic         st_req_ready,
  input  logic [127:0] st_req_data,
  input  logic         kw_req_valid,
  output logic         kw_req_ready,
  input  logic [31:0]  kw_req_data,
  output logic         st_out_valid,
  input  logic         st_out_ready,
  output logic [127:0] st_out_data,
  output logic         kw_out_valid,
  input  logic         kw_out_ready,
  output logic [31:0]  kw_out_data,
  output logic         busy,
  output logic         owner
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_q, state_d;
  logic [127:0] work_q, work_d;
  logic [3:0]   idx_q, idx_d;
  logic         owner_q, owner_d;

  logic         grant_kw, grant_st;
  logic         st_fire, kw_fire;
  logic [3:0]   last_idx;

  logic [3:0]   lane_idx [LANES];
  logic [6:0]   lane_lo  [LANES];
  logic [7:0]   sb_in    [LANES];
  logic [7:0]   sb_out   [LANES];

  // Each lane looks at byte idx+g of the work register (byte 0 = MSB).
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_idx[g] = idx_q + 4'(g);
    assign lane_lo[g]  = {~lane_idx[g], 3'b000};
    assign sb_in[g]    = work_q[lane_lo[g] +: 8];
    aes_sbox u_sbox (
      .in_byte (sb_in[g]),
      .out_byte(sb_out[g])
    );
  end

  // Round-robin grant; owner_q doubles as the last-grant record since both
  // reset to "state" and both change only on accept.
  always_comb begin
    grant_kw     = kw_req_valid && (!st_req_valid || !owner_q);
    grant_st     = st_req_valid && !grant_kw;
    st_req_ready = (state_q == IDLE) && grant_st;
    kw_req_ready = (state_q == IDLE) && grant_kw;
    st_fire      = st_req_valid && st_req_ready;
    kw_fire      = kw_req_valid && kw_req_ready;
    last_idx     = owner_q ? 4'(4 - LANES) : 4'(16 - LANES);
  end

  // Next-state logic: latch operand on accept, substitute one chunk per BUSY
  // cycle, then hold the result until the owner's consumer takes it.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    idx_d   = idx_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (st_fire) begin
          work_d  = st_req_data;
          idx_d   = '0;
          owner_d = 1'b0;
          state_d = BUSY;
        end else if (kw_fire) begin
          work_d  = {kw_req_data, 96'b0};
          idx_d   = '0;
          owner_d = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          work_d[lane_lo[l] +: 8] = sb_out[l];
        end
        idx_d = idx_q + 4'(LANES);
        if (idx_q == last_idx) begin
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if ((owner_q && kw_out_ready) || (!owner_q && st_out_ready)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; a reset mid-job drops it silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      idx_q   <= '0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      idx_q   <= idx_d;
      owner_q <= owner_d;
    end
  end

  // Results come straight from the work register; only the owner sees valid.
  always_comb begin
    st_out_valid = (state_q == DONE) && !owner_q;
    kw_out_valid = (state_q == DONE) && owner_q;
    st_out_data  = work_q;
    kw_out_data  = work_q[127:96];
    busy         = (state_q != IDLE);
    owner        = owner_q;
  end

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Bench for aes_sbox_sched: three instances (LANES = 1, 2, 4) driven from
// a vector table plus hand sequences for arbitration, backpressure and reset.
module tb_aes_sbox_sched;

  localparam logic [127:0] ST_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] ST_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [31:0]  KW_IN  = 32'hcf4f3c09;
  localparam logic [31:0]  KW_OUT = 32'h8a84eb01;

  logic         clk;
  logic         rst          [3];
  logic         st_req_valid [3];
  logic         st_req_ready [3];
  logic [127:0] st_req_data  [3];
  logic         kw_req_valid [3];
  logic         kw_req_ready [3];
  logic [31:0]  kw_req_data  [3];
  logic         st_out_valid [3];
  logic         st_out_ready [3];
  logic [127:0] st_out_data  [3];
  logic         kw_out_valid [3];
  logic         kw_out_ready [3];
  logic [31:0]  kw_out_data  [3];
  logic         busy         [3];
  logic         owner        [3];

  int n_checks = 0;
  int n_fail   = 0;

  // Instance 0: LANES=1, instance 1: LANES=2, instance 2: LANES=4.
  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam int LN = (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    aes_sbox_sched #(.LANES(LN)) u_dut (
      .clk         (clk),
      .rst         (rst[i]),
      .st_req_valid(st_req_valid[i]),
      .st_req_ready(st_req_ready[i]),
      .st_req_data (st_req_data[i]),
      .kw_req_valid(kw_req_valid[i]),
      .kw_req_ready(kw_req_ready[i]),
      .kw_req_data (kw_req_data[i]),
      .st_out_valid(st_out_valid[i]),
      .st_out_ready(st_out_ready[i]),
      .st_out_data (st_out_data[i]),
      .kw_out_valid(kw_out_valid[i]),
      .kw_out_ready(kw_out_ready[i]),
      .kw_out_data (kw_out_data[i]),
      .busy        (busy[i]),
      .owner       (owner[i])
    );
  end

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges outside a bounded wait.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    int           inst;
    bit           is_kw;
    logic [127:0] din;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs [8];

  task automatic check_output(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic report_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: timed out, expected event did not occur", name);
  endtask

  task automatic reset_all();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rst[i]          = 1'b1;
      st_req_valid[i] = 1'b0;
      kw_req_valid[i] = 1'b0;
      st_req_data[i]  = '0;
      kw_req_data[i]  = '0;
      st_out_ready[i] = 1'b1;
      kw_out_ready[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    #1;
  endtask

  // One complete job: request, accept, measure edges to result, handshake.
  task automatic apply_stimulus(input int inst, input bit is_kw,
                                input logic [127:0] din, input logic [127:0] exp,
                                input int lat, input string tag);
    bit got;
    int n;
    @(negedge clk);
    if (is_kw) begin
      kw_req_valid[inst] = 1'b1;
      kw_req_data[inst]  = din[31:0];
    end else begin
      st_req_valid[inst] = 1'b1;
      st_req_data[inst]  = din;
    end
    #1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      if (is_kw ? kw_req_ready[inst] : st_req_ready[inst]) got = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    if (!got) begin
      report_timeout({tag, "_accept"});
      st_req_valid[inst] = 1'b0;
      kw_req_valid[inst] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    st_req_valid[inst] = 1'b0;
    kw_req_valid[inst] = 1'b0;
    check_output({tag, "_busy_after_accept"}, busy[inst], 1);
    check_output({tag, "_owner"}, owner[inst], is_kw);
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (is_kw ? kw_out_valid[inst] : st_out_valid[inst]) got = 1'b1;
    end
    if (!got) begin
      report_timeout({tag, "_result"});
      return;
    end
    check_output({tag, "_latency"}, n, lat);
    if (is_kw) begin
      check_output({tag, "_data"}, kw_out_data[inst], exp[31:0]);
      check_output({tag, "_other_valid"}, st_out_valid[inst], 0);
    end else begin
      check_output({tag, "_data"}, st_out_data[inst], exp);
      check_output({tag, "_other_valid"}, kw_out_valid[inst], 0);
    end
    @(posedge clk);
    #1;
    check_output({tag, "_idle_after_hs"}, busy[inst], 0);
  endtask

  initial begin
    bit   order [$];
    int   both_cnt;
    int   stray;
    bit   got;

    vecs[0] = '{0, 1'b1, 128'h0053ff19, 128'h63ed16d4, 4};
    vecs[1] = '{2, 1'b0, ST_IN, ST_OUT, 4};
    vecs[2] = '{1, 1'b1, {96'b0, KW_IN}, {96'b0, KW_OUT}, 2};
    vecs[3] = '{0, 1'b0, ST_IN, ST_OUT, 16};
    vecs[4] = '{1, 1'b0, ST_IN, ST_OUT, 8};
    vecs[5] = '{2, 1'b1, {96'b0, KW_IN}, {96'b0, KW_OUT}, 1};
    vecs[6] = '{2, 1'b1, 128'h0, 128'h63636363, 1};
    vecs[7] = '{2, 1'b0, {128{1'b1}}, {16{8'h16}}, 4};

    reset_all();
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("rst_busy%0d", i), busy[i], 0);
      check_output($sformatf("rst_owner%0d", i), owner[i], 0);
      check_output($sformatf("rst_st_valid%0d", i), st_out_valid[i], 0);
      check_output($sformatf("rst_kw_valid%0d", i), kw_out_valid[i], 0);
      check_output($sformatf("rst_st_data%0d", i), st_out_data[i], 0);
      check_output($sformatf("rst_kw_data%0d", i), kw_out_data[i], 0);
      check_output($sformatf("rst_readies%0d", i),
                   {st_req_ready[i], kw_req_ready[i]}, 0);
    end

    for (int v = 0; v < 8; v++) begin
      apply_stimulus(vecs[v].inst, vecs[v].is_kw, vecs[v].din, vecs[v].exp,
                     vecs[v].lat, $sformatf("vec%0d", v));
    end

    // Simultaneous requests from reset: expect grants KW, ST, KW.
    reset_all();
    @(negedge clk);
    st_req_valid[2] = 1'b1;
    st_req_data[2]  = ST_IN;
    kw_req_valid[2] = 1'b1;
    kw_req_data[2]  = KW_IN;
    both_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (st_req_ready[2] && kw_req_ready[2]) both_cnt++;
      if (kw_req_ready[2]) order.push_back(1'b1);
      if (st_req_ready[2]) order.push_back(1'b0);
      if (kw_out_valid[2]) check_output("rr_kw_data", kw_out_data[2], KW_OUT);
      if (st_out_valid[2]) check_output("rr_st_data", st_out_data[2], ST_OUT);
      @(negedge clk);
    end
    st_req_valid[2] = 1'b0;
    kw_req_valid[2] = 1'b0;
    check_output("rr_both_ready", both_cnt, 0);
    if (order.size() < 3) begin
      report_timeout("rr_grant_count");
    end else begin
      check_output("rr_grant0", order[0], 1);
      check_output("rr_grant1", order[1], 0);
      check_output("rr_grant2", order[2], 1);
    end

    // Backpressure on the state result for 10 cycles.
    reset_all();
    st_out_ready[2] = 1'b0;
    @(negedge clk);
    st_req_valid[2] = 1'b1;
    st_req_data[2]  = ST_IN;
    #1;
    if (!st_req_ready[2]) report_timeout("bp_accept");
    @(posedge clk);
    #1;
    st_req_valid[2] = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk);
      #1;
      if (st_out_valid[2]) got = 1'b1;
    end
    if (!got) report_timeout("bp_result");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      st_req_valid[2] = 1'b1;
      kw_req_valid[2] = 1'b1;
      kw_req_data[2]  = KW_IN;
      #1;
      check_output("bp_valid", st_out_valid[2], 1);
      check_output("bp_data", st_out_data[2], ST_OUT);
      check_output("bp_readies", {st_req_ready[2], kw_req_ready[2]}, 0);
      check_output("bp_busy", busy[2], 1);
    end
    @(negedge clk);
    st_req_valid[2] = 1'b0;
    kw_req_valid[2] = 1'b0;
    st_out_ready[2] = 1'b1;
    @(posedge clk);
    #1;
    check_output("bp_release_busy", busy[2], 0);
    check_output("bp_release_valid", st_out_valid[2], 0);

    // Reset during chunk 2 of a LANES=1 state job.
    reset_all();
    @(negedge clk);
    st_req_valid[0] = 1'b1;
    st_req_data[0]  = ST_IN;
    #1;
    if (!st_req_ready[0]) report_timeout("mid_accept");
    @(posedge clk);
    #1;
    st_req_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    check_output("mid_busy", busy[0], 0);
    check_output("mid_owner", owner[0], 0);
    check_output("mid_valids", {st_out_valid[0], kw_out_valid[0]}, 0);
    check_output("mid_st_data", st_out_data[0], 0);
    check_output("mid_kw_data", kw_out_data[0], 0);
    @(negedge clk);
    rst[0] = 1'b0;
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (st_out_valid[0] || kw_out_valid[0] || busy[0]) stray++;
    end
    check_output("mid_no_output", stray, 0);
    apply_stimulus(0, 1'b1, 128'h0053ff19, 128'h63ed16d4, 4, "mid_after");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_sbox_sched.md
Name: aes_sbox_sched

Overview:
Time-shared scheduler for a small pool of `aes_sbox` instances. It serves two requesters:
- the round datapath, with full 128-bit SubBytes;
- the key expansion, with a 32-bit SubWord.

It arbitrates round-robin between them, walks the operand through LANES S-boxes per cycle, and returns the result on a valid/ready handshake. It sits between the round controller/key scheduler and the S-box instances, replacing 20 dedicated S-boxes.

Parameters:
- LANES, 4, number of `aes_sbox` instances used in parallel; legal values 1, 2, 4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- st_req_valid  in  1  state SubBytes request
- st_req_ready  out  1  state request accepted this cycle when both high
- st_req_data  in  128  state; byte 0 = bits [127:120] (FIPS order)
- kw_req_valid  in  1  key-word SubWord request
- kw_req_ready  out  1  key-word request accepted
- kw_req_data  in  32  word; byte 0 = bits [31:24]
- st_out_valid  out  1  SubBytes result valid
- st_out_ready  in  1  consumer accepts state result
- st_out_data  out  128  SubBytes(st_req_data)
- kw_out_valid  out  1  SubWord result valid
- kw_out_ready  in  1  consumer accepts word result
- kw_out_data  out  32  SubWord(kw_req_data)
- busy  out  1  FSM not in IDLE
- owner  out  1  0 = state job, 1 = key-word job (current or last)

Behaviour:
- One job at a time; no overlap of accept with an outstanding result.
- FSM states and transitions:
  - IDLE → BUSY on accept.
  - BUSY → DONE after the last chunk.
  - DONE → IDLE on out_valid && out_ready of the owner.
- Arbitration in IDLE:
  - One valid → that requester granted.
  - Both valid → the requester not granted last time wins (round-robin).
  - The last-grant register resets to "state", so the first tie goes to the key word.
  - st_req_ready/kw_req_ready = IDLE && grant to that side. They depend combinationally on the valids; no ready without the corresponding valid. Both readies are low outside IDLE.
- On accept:
  - Operand latched into a 128-bit work register (key word in the upper 32 bits).
  - Chunk counter cleared; owner updated.
- BUSY:
  - Each cycle, bytes [idx .. idx+LANES-1] go through the S-boxes and are written back in place; idx += LANES.
  - Number of BUSY cycles K = 16/LANES (state) or 4/LANES (word).
  - The S-box is combinational; the writeback is registered.
- Latency:
  - Accept at edge T → out_valid high from the cycle after edge T+K.
  - LANES=4: state result 5 cycles after accept, word result 2 cycles after.
  - LANES=1: 17 and 5 cycles.
- DONE:
  - Owner's out_valid high; data stable until handshake.
  - The other side's out_valid is 0.
  - Backpressure holds indefinitely.
  - Handshake returns the FSM to IDLE. A new request may be accepted on the cycle after, not on the handshake cycle.
- out_data is registered and reflects the work register; the key word is taken from bits [127:96].
- Reset values:
  - FSM in IDLE; busy=0, owner=0.
  - All out_valid=0, out_data=0, work register=0, counter=0, last-grant=state.
- Reset mid-operation: the job is dropped silently with no output; the next request starts clean.
- Requests deasserted before accept are simply not served. Requests do not have to hold while another job runs.

Test Plan:
- Single-byte spot check, LANES=1, key word 00 53 ff 19 → kw_out_data 63ed16d4 exactly 5 cycles after accept.
- State SubBytes, LANES=4:
  - Stimulus: st_req_data 193de3bea0f4e22b9ac68d2ae9f84808.
  - Required: st_out_data d42711aee0bf98f1b8b45de51e415230, out_valid 5 cycles after accept.
- Key word, LANES=2: kw_req_data cf4f3c09 → kw_out_data 8a84eb01, 3 cycles after accept.
- Simultaneous requests from reset:
  - Stimulus: both valid, both consumers always ready.
  - Required: key word served first, then state, then key word again (grant order KW, ST, KW), with the readies never high in the same cycle.
- Backpressure: hold st_out_ready=0 for 10 cycles → st_out_valid and data stable, both req_ready low, busy=1. Release → IDLE next cycle.
- Reset mid-BUSY: assert rst for 1 cycle during chunk 2 of a state job → no out_valid, all outputs 0. A subsequent word request completes correctly.
